// File: rtl/write_back_unit.sv
// write_back_unit
//
// Receiving end of the ALU write-back path. Each 8x8 result block (BLOCK_WORDS
// words) presented on iACCUMULATE either overwrites or is summed into a local
// accumulation buffer. On iFLUSH the buffer is streamed to DDR3 as
// BLOCK_WORDS/BEAT_WORDS Avalon-MM write beats, after which the buffer is cleared.
//
// Optional feature: define WRITE_BACK_SAT_ACCUM_EN to make the add-into-buffer
// path saturate to the signed WORD_W range instead of wrapping.
//
// Ports:
//   iCLK, iRST          clock (rising edge), synchronous active-high reset
//   iBLOCK              result block, word n in bits [n*WORD_W +: WORD_W]
//   iACCUMULATE         one-cycle strobe, iBLOCK valid
//   iCLEAR              with iACCUMULATE: 1 = overwrite, 0 = add
//   iFLUSH              one-cycle strobe, stream buffer to DDR3
//   iBASE_ADDR          beat address of beat 0, sampled with iFLUSH
//   oAVL_WRITE/ADDR/WDATA, iAVL_WAITREQUEST   Avalon-MM write master
//   oBUSY               high while flushing
//   oDONE               one-cycle pulse after the last beat is accepted
//   oOVERRUN            sticky, an accumulate or flush was dropped
module write_back_unit #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 64,
    parameter int unsigned BEAT_WORDS  = 4,
    parameter int unsigned ADDR_W      = 25
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic [BLOCK_WORDS*WORD_W-1:0]  iBLOCK,
    input  logic                           iACCUMULATE,
    input  logic                           iCLEAR,
    input  logic                           iFLUSH,
    input  logic [ADDR_W-1:0]              iBASE_ADDR,
    output logic                           oAVL_WRITE,
    output logic [ADDR_W-1:0]              oAVL_ADDR,
    output logic [BEAT_WORDS*WORD_W-1:0]   oAVL_WDATA,
    input  logic                           iAVL_WAITREQUEST,
    output logic                           oBUSY,
    output logic                           oDONE,
    output logic                           oOVERRUN
);

    localparam int unsigned BEATS = BLOCK_WORDS / BEAT_WORDS;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BW_W  = (BEAT_WORDS > 1) ? $clog2(BEAT_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  overrun_q, overrun_d;
    logic [WORD_W-1:0]     mem_q [BLOCK_WORDS];
    logic [WORD_W-1:0]     mem_d [BLOCK_WORDS];

    // Add used for iCLEAR=0; wraps by default, clamps to the signed range when
    // the saturating build is selected.
    function automatic logic [WORD_W-1:0] acc_add(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] sum;
        sum = a + b;
`ifdef WRITE_BACK_SAT_ACCUM_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1])) begin
            sum = a[WORD_W-1] ? {1'b1, {(WORD_W-1){1'b0}}} : {1'b0, {(WORD_W-1){1'b1}}};
        end
`endif
        return sum;
    endfunction

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        overrun_d = overrun_q;
        mem_d     = mem_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (iACCUMULATE) begin
                    for (int n = 0; n < int'(BLOCK_WORDS); n++) begin
                        mem_d[n] = iCLEAR ? iBLOCK[n*WORD_W +: WORD_W]
                                          : acc_add(mem_q[n], iBLOCK[n*WORD_W +: WORD_W]);
                    end
                end
                // The flush streams mem_q from the next cycle on, so a same-cycle
                // accumulate is already visible in the first beat.
                if (iFLUSH) begin
                    base_d  = iBASE_ADDR;
                    beat_d  = '0;
                    state_d = StFlush;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (iACCUMULATE || iFLUSH) begin
                    overrun_d = 1'b1;
                end
                if (!iAVL_WAITREQUEST) begin
                    if (beat_q == LAST_BEAT) begin
                        for (int n = 0; n < int'(BLOCK_WORDS); n++) begin
                            mem_d[n] = '0;
                        end
                        beat_d  = '0;
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            base_q    <= '0;
            overrun_q <= 1'b0;
            for (int n = 0; n < int'(BLOCK_WORDS); n++) begin
                mem_q[n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            overrun_q <= overrun_d;
            for (int n = 0; n < int'(BLOCK_WORDS); n++) begin
                mem_q[n] <= mem_d[n];
            end
        end
    end

    // Beat data: buffer words {beat, j}, word 4k in the low lane.
    logic [BEAT_WORDS*WORD_W-1:0] beat_data;

    for (genvar j = 0; j < int'(BEAT_WORDS); j++) begin : g_lane
        assign beat_data[j*WORD_W +: WORD_W] = mem_q[{beat_q, BW_W'(j)}];
    end

    always_comb begin
        oBUSY      = (state_q == StFlush);
        oAVL_WRITE = (state_q == StFlush);
        oDONE      = (state_q == StDone);
        oOVERRUN   = overrun_q;
        // Address/data are driven only during a burst so they read zero otherwise.
        oAVL_ADDR  = oAVL_WRITE ? (base_q + ADDR_W'(beat_q)) : '0;
        oAVL_WDATA = oAVL_WRITE ? beat_data : '0;
    end

endmodule

// File: tb/tb_write_back_unit.sv
module tb_write_back_unit;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 64;
    localparam int BEAT_WORDS  = 4;
    localparam int ADDR_W      = 25;
    localparam int BEATS       = BLOCK_WORDS / BEAT_WORDS;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [BLOCK_WORDS*WORD_W-1:0] blk;
    logic                          acc;
    logic                          clr;
    logic                          flush;
    logic [ADDR_W-1:0]             base;
    logic                          waitreq;
    logic                          avl_write;
    logic [ADDR_W-1:0]             avl_addr;
    logic [BEAT_WORDS*WORD_W-1:0]  avl_wdata;
    logic                          busy;
    logic                          done;
    logic                          overrun;

    always #5 clk = ~clk;

    write_back_unit dut (
        .iCLK             (clk),
        .iRST             (rst),
        .iBLOCK           (blk),
        .iACCUMULATE      (acc),
        .iCLEAR           (clr),
        .iFLUSH           (flush),
        .iBASE_ADDR       (base),
        .oAVL_WRITE       (avl_write),
        .oAVL_ADDR        (avl_addr),
        .oAVL_WDATA       (avl_wdata),
        .iAVL_WAITREQUEST (waitreq),
        .oBUSY            (busy),
        .oDONE            (done),
        .oOVERRUN         (overrun)
    );

    typedef struct packed {
        logic [ADDR_W-1:0]            addr;
        logic [BEAT_WORDS*WORD_W-1:0] data;
    } beat_t;

    beat_t       beat_q[$];
    int          done_q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [BLOCK_WORDS];
    logic [31:0] vec   [BLOCK_WORDS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: every presented beat must match the head of the scoreboard,
    // which only advances on acceptance (so stalled beats are rechecked).
    always @(negedge clk) begin
        if (avl_write) begin
            if (beat_q.size() == 0) begin
                unexpected("unexpected beat");
            end else begin
                check("beat addr", 128'(avl_addr), 128'(beat_q[0].addr));
                check("beat data", avl_wdata, beat_q[0].data);
                if (!waitreq) void'(beat_q.pop_front());
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                unexpected("unexpected done");
            end else begin
                int exp_cyc;
                exp_cyc = done_q.pop_front();
                check("done cycle", 128'(cyc), 128'(exp_cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One command cycle: optional accumulate of vec, optional flush. Pushes
    // n_beats expected beats and, if done_delay > 0, the expected oDONE cycle.
    task automatic cycle_cmd(input bit do_acc, input bit clear, input bit do_flush,
                             input logic [ADDR_W-1:0] b, input int n_beats,
                             input int done_delay);
        beat_t bt;
        if (do_acc) begin
            for (int n = 0; n < BLOCK_WORDS; n++) begin
                blk[n*WORD_W +: WORD_W] = vec[n];
                model[n] = clear ? vec[n] : model[n] + vec[n];
            end
        end
        acc = do_acc;
        clr = clear;
        if (do_flush) begin
            for (int k = 0; k < n_beats; k++) begin
                bt.addr = b + ADDR_W'(k);
                bt.data = {model[4*k+3], model[4*k+2], model[4*k+1], model[4*k]};
                beat_q.push_back(bt);
            end
            if (done_delay > 0) done_q.push_back(cyc + done_delay);
            for (int n = 0; n < BLOCK_WORDS; n++) model[n] = '0;
        end
        flush = do_flush;
        base  = b;
        tick();
        acc   = 1'b0;
        clr   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; blk = '0; acc = 1'b0; clr = 1'b0; flush = 1'b0;
        base = '0; waitreq = 1'b0;
        for (int n = 0; n < BLOCK_WORDS; n++) model[n] = '0;
        idle(2);
        check("reset write", 128'(avl_write), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset overrun", 128'(overrun), 128'(0));
        check("reset addr", 128'(avl_addr), 128'(0));
        check("reset wdata", avl_wdata, 128'(0));
        rst = 1'b0;
        tick();

        // Overwrite with word n = n, flush at 0x100; beat 1 = {7,6,5,4}.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'(n);
        cycle_cmd(1, 1, 0, '0, 0, 0);
        cycle_cmd(0, 0, 1, 25'h100, BEATS, 17);
        idle(20);
        check("drain overwrite", 128'(beat_q.size()), 128'(0));

        // 5 overwrite + 3 add = 8 everywhere; then an empty flush of zeros.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'd5;
        cycle_cmd(1, 1, 0, '0, 0, 0);
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'd3;
        cycle_cmd(1, 0, 0, '0, 0, 0);
        cycle_cmd(0, 0, 1, 25'h200, BEATS, 17);
        idle(20);
        cycle_cmd(0, 0, 1, 25'h300, BEATS, 17);
        idle(20);
        check("drain accumulate", 128'(beat_q.size()), 128'(0));

        // Stall beat 7 for 3 cycles.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'(n * 16 + 1);
        cycle_cmd(1, 1, 0, '0, 0, 0);
        cycle_cmd(0, 0, 1, 25'h400, BEATS, 20);
        idle(7);
        check("stall beat7 addr", 128'(avl_addr), 128'(25'h407));
        waitreq = 1'b1;
        idle(3);
        waitreq = 1'b0;
        idle(15);
        check("drain stall", 128'(beat_q.size()), 128'(0));

        // Overflow in both directions plus a non-overflowing negative add.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = '0;
        vec[0] = 32'h7FFF_FFFF; vec[1] = 32'h8000_0000; vec[2] = 32'hFFFF_FFF0;
        cycle_cmd(1, 1, 0, '0, 0, 0);
        vec[0] = 32'h0000_0001; vec[1] = 32'hFFFF_FFFF; vec[2] = 32'h0000_0005;
        cycle_cmd(1, 0, 0, '0, 0, 0);
`ifdef WRITE_BACK_SAT_ACCUM_EN
        model[0] = 32'h7FFF_FFFF;
        model[1] = 32'h8000_0000;
`else
        model[0] = 32'h8000_0000;
        model[1] = 32'h7FFF_FFFF;
`endif
        model[2] = 32'hFFFF_FFF5;
        cycle_cmd(0, 0, 1, 25'h500, BEATS, 17);
        idle(20);

        // Accumulate arriving at beat 5 is dropped and flags overrun.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'(n + 100);
        cycle_cmd(1, 1, 0, '0, 0, 0);
        cycle_cmd(0, 0, 1, 25'h600, BEATS, 17);
        idle(5);
        check("collision beat5 addr", 128'(avl_addr), 128'(25'h605));
        for (int n = 0; n < BLOCK_WORDS; n++) blk[n*WORD_W +: WORD_W] = 32'hAA;
        acc = 1'b1;
        clr = 1'b1;
        tick();
        acc = 1'b0;
        clr = 1'b0;
        check("overrun set", 128'(overrun), 128'(1));
        idle(15);
        cycle_cmd(0, 0, 1, 25'h700, BEATS, 17);
        idle(20);
        // Same-cycle overwrite and flush streams the new 9s.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'd9;
        cycle_cmd(1, 1, 1, 25'h800, BEATS, 17);
        idle(20);
        check("overrun sticky", 128'(overrun), 128'(1));
        check("drain collision", 128'(beat_q.size()), 128'(0));

        // Reset while beat 10 is presented aborts the burst.
        for (int n = 0; n < BLOCK_WORDS; n++) vec[n] = 32'(n + 1);
        cycle_cmd(1, 1, 0, '0, 0, 0);
        cycle_cmd(0, 0, 1, 25'h900, 11, 0);
        idle(10);
        check("reset beat10 addr", 128'(avl_addr), 128'(25'h90A));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort write", 128'(avl_write), 128'(0));
        check("abort busy", 128'(busy), 128'(0));
        check("abort done", 128'(done), 128'(0));
        check("abort overrun", 128'(overrun), 128'(0));
        idle(20);
        cycle_cmd(0, 0, 1, 25'hA00, BEATS, 17);
        idle(20);

        check("beats drained", 128'(beat_q.size()), 128'(0));
        check("dones drained", 128'(done_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
